// File: rtl/ctrl_burst_data.sv
// ============================================================================
// Module      : ctrl_burst_data
// Description : Data-phase sequencer for the CAS controller handshake. Each
//               issued CAS becomes a read-capture or write-drive burst window
//               that opens RL=AL+CL or WL=AL+CWL clocks after the command.
//               The optional write DQS preamble is built in only when the
//               CTRL_WR_PREAMBLE_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_burst_data #(
  parameter int MAX_LAT = 48,
  parameter int LAT_W   = 6
) (
  input  logic       CK_t,
  input  logic       reset,
  input  logic       cas_rdy,
  input  logic [2:0] cas_req,
  input  logic [4:0] CL,
  input  logic [4:0] AL,
  input  logic [4:0] CWL,
  input  logic [4:0] BL,
  output logic       rd_valid,
  output logic       wr_valid,
  output logic [1:0] beat_idx,
  output logic       rw_done,
  output logic       auto_pre,
  output logic       data_busy,
  output logic       lat_err,
`ifdef CTRL_WR_PREAMBLE_EN
  output logic       overlap_err,
  output logic       wr_dqs_oe
`else
  output logic       overlap_err
`endif
);

  // Request codes, matching the ddr_pkg encoding used by the CAS controller
  localparam logic [2:0] c_RD_R  = 3'd1;
  localparam logic [2:0] c_RDA_R = 3'd2;
  localparam logic [2:0] c_WR_R  = 3'd3;
  localparam logic [2:0] c_WRA_R = 3'd4;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_RD   = 2'd1,
    D_WR   = 2'd2
  } state_t;

  state_t              r_state;
  logic [1:0]          r_beat;
  logic [1:0]          r_last;
  logic                r_cur_ap;
  logic                r_done;
  logic                r_ap_out;
  logic                r_lat_err;
  logic                r_ovl_err;
  // Token pipeline; stage 0 is the stage that matures on the coming edge
  logic [MAX_LAT-1:0]  r_pv;
  logic [MAX_LAT-1:0]  r_pw;
  logic [MAX_LAT-1:0]  r_pa;

  logic                w_is_rd;
  logic                w_is_wr;
  logic                w_is_ap;
  logic                w_cmd;
  logic [LAT_W-1:0]    w_lat;
  logic [LAT_W-1:0]    w_min_lat;
  logic                w_lat_bad;
  logic                w_ins;
  logic [LAT_W-1:0]    w_slot;
  logic [MAX_LAT-1:0]  w_shift_v;
  logic                w_collide;
  logic                w_mat;
  logic                w_start;
  logic                w_ovl_mature;
  logic [1:0]          w_new_last;

  assign w_is_rd = (cas_req == c_RD_R) || (cas_req == c_RDA_R);
  assign w_is_wr = (cas_req == c_WR_R) || (cas_req == c_WRA_R);
  assign w_is_ap = (cas_req == c_RDA_R) || (cas_req == c_WRA_R);
  assign w_cmd   = cas_rdy && (w_is_rd || w_is_wr);
  assign w_lat   = w_is_wr ? (LAT_W'(AL) + LAT_W'(CWL)) : (LAT_W'(AL) + LAT_W'(CL));

`ifdef CTRL_WR_PREAMBLE_EN
  // Writes need one extra clock of lead time to open the DQS preamble
  assign w_min_lat = w_is_wr ? LAT_W'(3) : LAT_W'(2);
`else
  assign w_min_lat = LAT_W'(2);
`endif

  assign w_lat_bad = (w_lat < w_min_lat) || (w_lat > LAT_W'(MAX_LAT));
  assign w_ins     = w_cmd && !w_lat_bad;
  // A token inserted at slot L-2 reaches stage 0 one clock before its burst
  assign w_slot    = w_lat - LAT_W'(2);
  assign w_shift_v = {1'b0, r_pv[MAX_LAT-1:1]};

  // Detect an insert landing on a stage already holding a shifted token
  always_comb begin
    w_collide = 1'b0;
    for (int i = 0; i < MAX_LAT; i++) begin
      if ((w_slot == LAT_W'(i)) && w_shift_v[i]) begin
        w_collide = 1'b1;
      end
    end
    w_collide = w_collide && w_ins;
  end

  assign w_mat        = r_pv[0];
  assign w_start      = w_mat && ((r_state == D_IDLE) || (r_beat == r_last));
  assign w_ovl_mature = w_mat && (r_state != D_IDLE) && (r_beat != r_last);
  // BL of 4 gives two beats; every other value is handled as BL8
  assign w_new_last   = (BL == 5'd4) ? 2'd1 : 2'd3;

  // Shift the token pipeline and insert at most one new token per clock
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      r_pv <= '0;
      r_pw <= '0;
      r_pa <= '0;
    end else begin
      r_pv <= {1'b0, r_pv[MAX_LAT-1:1]};
      r_pw <= {1'b0, r_pw[MAX_LAT-1:1]};
      r_pa <= {1'b0, r_pa[MAX_LAT-1:1]};
      for (int i = 0; i < MAX_LAT; i++) begin
        if (w_ins && (w_slot == LAT_W'(i))) begin
          r_pv[i] <= 1'b1;
          r_pw[i] <= w_is_wr;
          r_pa[i] <= w_is_ap;
        end
      end
    end
  end

  // Burst FSM: start on a maturing token, count beats, pulse done on the last
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      r_state  <= D_IDLE;
      r_beat   <= 2'd0;
      r_last   <= 2'd0;
      r_cur_ap <= 1'b0;
      r_done   <= 1'b0;
      r_ap_out <= 1'b0;
    end else if (w_start) begin
      r_state  <= r_pw[0] ? D_WR : D_RD;
      r_beat   <= 2'd0;
      r_last   <= w_new_last;
      r_cur_ap <= r_pa[0];
      r_done   <= 1'b0;
      r_ap_out <= 1'b0;
    end else if ((r_state != D_IDLE) && (r_beat != r_last)) begin
      r_beat   <= r_beat + 2'd1;
      r_done   <= ((r_beat + 2'd1) == r_last);
      r_ap_out <= ((r_beat + 2'd1) == r_last) && r_cur_ap;
    end else begin
      r_state  <= D_IDLE;
      r_beat   <= 2'd0;
      r_done   <= 1'b0;
      r_ap_out <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      r_lat_err <= 1'b0;
      r_ovl_err <= 1'b0;
    end else begin
      if (w_cmd && w_lat_bad) begin
        r_lat_err <= 1'b1;
      end
      if (w_ovl_mature || w_collide) begin
        r_ovl_err <= 1'b1;
      end
    end
  end

  assign rd_valid    = (r_state == D_RD);
  assign wr_valid    = (r_state == D_WR);
  assign beat_idx    = r_beat;
  assign rw_done     = r_done;
  assign auto_pre    = r_ap_out;
  assign data_busy   = (r_state != D_IDLE) || (|r_pv);
  assign lat_err     = r_lat_err;
  assign overlap_err = r_ovl_err;

`ifdef CTRL_WR_PREAMBLE_EN
  // DQS enable opens one clock ahead of a write maturing from idle or a read
  assign wr_dqs_oe = (r_state == D_WR) || (r_pv[0] && r_pw[0] && (r_state != D_WR));
`endif

endmodule

`default_nettype wire
